// File: rtl/uart_prog_loader.sv
// Boot-time UART program loader: receives an A5/length-framed image, writes 32-bit words to imem.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [32:0]   MAX_WORDS = 33'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

  logic      rx_meta, rx_sync, rx_prev;
  rx_state_t rx_state;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  state_t                state;
  logic [7:0]            len_lo;
  logic [15:0]           remain;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [1:0]            byte_idx;
  logic [23:0]           word_lo;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // Serial receiver: start bit re-checked at half-bit to reject glitches, data sampled mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame parser; start aborts any in-progress frame and re-arms from DONE/ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      remain     <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_lo    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        state    <= S_IDLE;
        done     <= 1'b0;
        err      <= 1'b0;
        cpu_hold <= 1'b1;
      end else if (frame_err && state != S_DONE && state != S_ERR) begin
        state    <= S_ERR;
        err      <= 1'b1;
        cpu_hold <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (byte_valid && rx_byte == 8'hA5) state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            if (byte_valid) begin
              len_lo <= rx_byte;
              state  <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (byte_valid) begin
              byte_idx <= '0;
              word_cnt <= '0;
              remain   <= {rx_byte, len_lo};
`ifdef LOADER_CHECKSUM_EN
              csum     <= '0;
`endif
              if ({rx_byte, len_lo} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state    <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
`endif
              end else if ({17'd0, rx_byte, len_lo} > MAX_WORDS) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (imem_we) begin
              word_cnt <= word_cnt + 1'b1;
              remain   <= remain - 16'd1;
              if (remain == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state    <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
`endif
              end
            end else if (byte_valid) begin
              byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
              csum     <= csum ^ rx_byte;
`endif
              case (byte_idx)
                2'd0: word_lo[7:0]   <= rx_byte;
                2'd1: word_lo[15:8]  <= rx_byte;
                2'd2: word_lo[23:16] <= rx_byte;
                default: begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_cnt;
                  imem_wdata <= {rx_byte, word_lo};
                end
              endcase
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (byte_valid) begin
              if (rx_byte == csum) begin
                state    <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state <= S_ERR;
                err   <= 1'b1;
              end
            end
          end
`endif
          S_DONE: begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
          S_ERR: begin
            err      <= 1'b1;
            cpu_hold <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
